// File: rtl/adc_i2s_rx.sv
// I2S slave receiver: synchronises the external bit clock, word select and
// serial data into i_clock, deserialises left/right slots MSB-first and
// presents each complete stereo pair with a one-cycle strobe.
module adc_i2s_rx #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned SLOT_BITS     = 32,
  parameter int unsigned TIMEOUT_TICKS = 256
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_bit_clock,
  input  logic                  i_LR_clock,
  input  logic                  i_data,
  output logic [DATA_WIDTH-1:0] o_left,
  output logic [DATA_WIDTH-1:0] o_right,
  output logic                  o_valid,
  output logic                  o_locked,
  output logic                  o_frame_error
);

  localparam int unsigned            IDLE_W   = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [IDLE_W-1:0]      IDLE_MAX = IDLE_W'(TIMEOUT_TICKS);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_RIGHT_SKIP,
    ST_LEFT,
    ST_RIGHT
  } state_t;

  state_t                state;
  logic                  bclk_s1, bclk_s2, bclk_s3;
  logic                  lr_s1, lr_s2;
  logic                  data_s1, data_s2;
  logic                  tick_q, lr_q, data_q;
  logic                  lr_prev;
  logic [5:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] word_next;
  logic [IDLE_W-1:0]     idle_cnt;
  logic                  len_ok;

  // Current word with this tick's data bit placed at the slot position (MSB first).
  always_comb begin
    word_next = word;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (32'(bit_cnt) == DATA_WIDTH - 1 - i) word_next[i] = data_q;
    end
    len_ok = (32'(bit_cnt) + 32'd1) == SLOT_BITS;
  end

  // Synchronisers, registered edge detect, slot assembly, framing FSM and outputs.
  // The tick is registered together with LR/data so all three stay aligned.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      bclk_s1       <= 1'b0;
      bclk_s2       <= 1'b0;
      bclk_s3       <= 1'b0;
      lr_s1         <= 1'b0;
      lr_s2         <= 1'b0;
      data_s1       <= 1'b0;
      data_s2       <= 1'b0;
      tick_q        <= 1'b0;
      lr_q          <= 1'b0;
      data_q        <= 1'b0;
      lr_prev       <= 1'b0;
      bit_cnt       <= '0;
      word          <= '0;
      idle_cnt      <= '0;
      state         <= ST_SEARCH;
      o_left        <= '0;
      o_right       <= '0;
      o_valid       <= 1'b0;
      o_locked      <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      bclk_s1       <= i_bit_clock;
      bclk_s2       <= bclk_s1;
      bclk_s3       <= bclk_s2;
      lr_s1         <= i_LR_clock;
      lr_s2         <= lr_s1;
      data_s1       <= i_data;
      data_s2       <= data_s1;
      tick_q        <= bclk_s2 & ~bclk_s3;
      lr_q          <= lr_s2;
      data_q        <= data_s2;
      o_valid       <= 1'b0;
      o_frame_error <= 1'b0;

      if (tick_q) begin
        idle_cnt <= '0;
        lr_prev  <= lr_q;
        if (lr_q != lr_prev) begin
          // This tick carries the LSB of the slot that belonged to lr_prev.
          bit_cnt <= '0;
          word    <= '0;
          case (state)
            ST_SEARCH: begin
              state    <= lr_q ? ST_LEFT : ST_RIGHT_SKIP;
              o_locked <= lr_q;
            end
            ST_RIGHT_SKIP: begin
              state    <= ST_LEFT;
              o_locked <= 1'b1;
            end
            ST_LEFT: begin
              if (len_ok) begin
                o_left <= word_next;
                state  <= ST_RIGHT;
              end else begin
                o_frame_error <= 1'b1;
                o_locked      <= 1'b0;
                state         <= ST_SEARCH;
              end
            end
            ST_RIGHT: begin
              if (len_ok) begin
                o_right <= word_next;
                o_valid <= 1'b1;
                state   <= ST_LEFT;
              end else begin
                o_frame_error <= 1'b1;
                o_locked      <= 1'b0;
                state         <= ST_SEARCH;
              end
            end
            default: begin
              state    <= ST_SEARCH;
              o_locked <= 1'b0;
            end
          endcase
        end else begin
          word <= word_next;
          if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
        end
      end else if (idle_cnt == IDLE_MAX) begin
        state    <= ST_SEARCH;
        o_locked <= 1'b0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_i2s_rx.sv
// Directed bench for adc_i2s_rx: a 32-bit and a 24-bit receiver share one
// I2S stream generated bit by bit with the one-bit LR lead.
module tb_adc_i2s_rx;

  localparam int HALF = 4;

  typedef struct {
    logic        chan;
    logic [31:0] word;
    int          len;
  } slot_t;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_bit_clock = 1'b0;
  logic        i_LR_clock = 1'b0;
  logic        i_data = 1'b0;

  logic [31:0] l32, r32;
  logic        v32, k32, f32;
  logic [23:0] l24, r24;
  logic        v24, k24, f24;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int v32_cnt = 0, f32_cnt = 0, v24_cnt = 0, f24_cnt = 0, both_cnt = 0;
  int v32_cyc = 0;
  int last_rise = 0;
  slot_t slot_q[$];

  adc_i2s_rx #(.DATA_WIDTH(32), .SLOT_BITS(32), .TIMEOUT_TICKS(256)) dut32 (
    .i_clock(i_clock), .i_reset(i_reset), .i_bit_clock(i_bit_clock),
    .i_LR_clock(i_LR_clock), .i_data(i_data), .o_left(l32), .o_right(r32),
    .o_valid(v32), .o_locked(k32), .o_frame_error(f32)
  );

  adc_i2s_rx #(.DATA_WIDTH(24), .SLOT_BITS(32), .TIMEOUT_TICKS(256)) dut24 (
    .i_clock(i_clock), .i_reset(i_reset), .i_bit_clock(i_bit_clock),
    .i_LR_clock(i_LR_clock), .i_data(i_data), .o_left(l24), .o_right(r24),
    .o_valid(v24), .o_locked(k24), .o_frame_error(f24)
  );

  always #5 i_clock = ~i_clock;

  always @(posedge i_clock) cyc <= cyc + 1;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge i_clock) begin
    if (v32) begin
      v32_cnt <= v32_cnt + 1;
      v32_cyc <= cyc;
    end
    if (f32) f32_cnt <= f32_cnt + 1;
    if (v24) v24_cnt <= v24_cnt + 1;
    if (f24) f24_cnt <= f24_cnt + 1;
    if ((v32 && f32) || (v24 && f24)) both_cnt <= both_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge i_clock);
    #1;
  endtask

  task automatic push_slot(input logic chan, input logic [31:0] word, input int len);
    slot_t s;
    s.chan = chan;
    s.word = word;
    s.len  = len;
    slot_q.push_back(s);
  endtask

  task automatic send_bit(input logic lr, input logic d);
    i_LR_clock = lr;
    i_data     = d;
    wait_clk(HALF);
    i_bit_clock = 1'b1;
    last_rise   = cyc;
    wait_clk(HALF);
    i_bit_clock = 1'b0;
  endtask

  // Plays the queued slots; LR switches one bit early, on the LSB of the ending slot.
  task automatic play();
    logic [31:0] w;
    logic        lr;
    for (int i = 0; i < slot_q.size(); i++) begin
      w = slot_q[i].word;
      for (int j = 0; j < slot_q[i].len; j++) begin
        if (j == slot_q[i].len - 1)
          lr = (i + 1 < slot_q.size()) ? slot_q[i+1].chan : ~slot_q[i].chan;
        else
          lr = slot_q[i].chan;
        send_bit(lr, w[31-j]);
      end
    end
    slot_q.delete();
    wait_clk(4);
  endtask

  task automatic test_reset();
    total++; if (l32 !== 32'h0) begin bad++; $display("FAIL reset_left got %h want %h", l32, 32'h0); end
    total++; if (r32 !== 32'h0) begin bad++; $display("FAIL reset_right got %h want %h", r32, 32'h0); end
    total++; if (v32 !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", v32); end
    total++; if (k32 !== 1'b0) begin bad++; $display("FAIL reset_locked got %b want 0", k32); end
    total++; if (f32 !== 1'b0) begin bad++; $display("FAIL reset_ferr got %b want 0", f32); end
    total++; if ({l24, r24, v24, k24, f24} !== 51'h0) begin
      bad++; $display("FAIL reset_dut24 got %h want 0", {l24, r24, v24, k24, f24});
    end
  endtask

  task automatic test_stream();
    int v0, f0;
    v0 = v32_cnt; f0 = f32_cnt;
    push_slot(1'b0, 32'hDEADBEEF, 32);
    push_slot(1'b1, 32'h12345678, 32);
    push_slot(1'b0, 32'h9ABCDEF0, 32);
    play();
    total++; if (v32_cnt - v0 !== 1) begin bad++; $display("FAIL stream_valid_count got %0d want 1", v32_cnt - v0); end
    total++; if (f32_cnt - f0 !== 0) begin bad++; $display("FAIL stream_ferr_count got %0d want 0", f32_cnt - f0); end
    total++; if (l32 !== 32'h12345678) begin bad++; $display("FAIL stream_left got %h want %h", l32, 32'h12345678); end
    total++; if (r32 !== 32'h9ABCDEF0) begin bad++; $display("FAIL stream_right got %h want %h", r32, 32'h9ABCDEF0); end
    total++; if (k32 !== 1'b1) begin bad++; $display("FAIL stream_locked got %b want 1", k32); end
    total++; if (v32_cyc - last_rise !== 4) begin
      bad++; $display("FAIL stream_latency got %0d want 4", v32_cyc - last_rise);
    end
    total++; if (l24 !== 24'h123456 || r24 !== 24'h9ABCDE) begin
      bad++; $display("FAIL stream_dut24 got %h/%h want 123456/9abcde", l24, r24);
    end
  endtask

  task automatic test_loop();
    int v0;
    for (int n = 0; n < 3; n++) begin
      v0 = v32_cnt;
      push_slot(1'b1, 32'hA5A50001, 32);
      push_slot(1'b0, 32'hA5A50001, 32);
      play();
      total++; if (v32_cnt - v0 !== 1) begin bad++; $display("FAIL loop_valid_count[%0d] got %0d want 1", n, v32_cnt - v0); end
      total++; if (l32 !== 32'hA5A50001) begin bad++; $display("FAIL loop_left[%0d] got %h want a5a50001", n, l32); end
      total++; if (r32 !== 32'hA5A50001) begin bad++; $display("FAIL loop_right[%0d] got %h want a5a50001", n, r32); end
    end
  endtask

  task automatic test_frame_error();
    int v0, f0, g0;
    v0 = v32_cnt; f0 = f32_cnt; g0 = f24_cnt;
    push_slot(1'b1, 32'h0F0F0F0F, 32);
    push_slot(1'b0, 32'h11223344, 31);
    play();
    total++; if (f32_cnt - f0 !== 1) begin bad++; $display("FAIL ferr_pulse got %0d want 1", f32_cnt - f0); end
    total++; if (f24_cnt - g0 !== 1) begin bad++; $display("FAIL ferr_pulse24 got %0d want 1", f24_cnt - g0); end
    total++; if (v32_cnt - v0 !== 0) begin bad++; $display("FAIL ferr_no_valid got %0d want 0", v32_cnt - v0); end
    total++; if (k32 !== 1'b0) begin bad++; $display("FAIL ferr_unlocked got %b want 0", k32); end
    total++; if (r32 !== 32'hA5A50001) begin bad++; $display("FAIL ferr_right_hold got %h want a5a50001", r32); end
    // First following frame only realigns.
    push_slot(1'b1, 32'h01010101, 32);
    push_slot(1'b0, 32'h02020202, 32);
    play();
    total++; if (v32_cnt - v0 !== 0) begin bad++; $display("FAIL relock_no_valid got %0d want 0", v32_cnt - v0); end
    total++; if (k32 !== 1'b1) begin bad++; $display("FAIL relock_locked got %b want 1", k32); end
    total++; if (l32 !== 32'h0F0F0F0F) begin bad++; $display("FAIL relock_left_hold got %h want 0f0f0f0f", l32); end
    push_slot(1'b1, 32'h03030303, 32);
    push_slot(1'b0, 32'h04040404, 32);
    play();
    total++; if (v32_cnt - v0 !== 1) begin bad++; $display("FAIL relock_valid got %0d want 1", v32_cnt - v0); end
    total++; if (l32 !== 32'h03030303 || r32 !== 32'h04040404) begin
      bad++; $display("FAIL relock_pair got %h/%h want 03030303/04040404", l32, r32);
    end
    total++; if (f32_cnt - f0 !== 1) begin bad++; $display("FAIL relock_ferr_count got %0d want 1", f32_cnt - f0); end
  endtask

  task automatic test_dw24();
    int v0, g0;
    v0 = v24_cnt; g0 = f24_cnt;
    push_slot(1'b1, 32'hFFEEDDCC, 32);
    push_slot(1'b0, 32'h00112233, 32);
    play();
    total++; if (l24 !== 24'hFFEEDD) begin bad++; $display("FAIL dw24_left got %h want ffeedd", l24); end
    total++; if (r24 !== 24'h001122) begin bad++; $display("FAIL dw24_right got %h want 001122", r24); end
    total++; if (f24_cnt - g0 !== 0) begin bad++; $display("FAIL dw24_ferr got %0d want 0", f24_cnt - g0); end
    total++; if (v24_cnt - v0 !== 1) begin bad++; $display("FAIL dw24_valid got %0d want 1", v24_cnt - v0); end
    total++; if (l32 !== 32'hFFEEDDCC) begin bad++; $display("FAIL dw32_left got %h want ffeeddcc", l32); end
  endtask

  task automatic test_timeout();
    int v0, f0;
    v0 = v32_cnt; f0 = f32_cnt;
    wait_clk(230);
    total++; if (k32 !== 1'b1) begin bad++; $display("FAIL timeout_early got %b want 1", k32); end
    wait_clk(30);
    total++; if (k32 !== 1'b0 || k24 !== 1'b0) begin
      bad++; $display("FAIL timeout_unlock got %b/%b want 0/0", k32, k24);
    end
    total++; if (l32 !== 32'hFFEEDDCC || r32 !== 32'h00112233) begin
      bad++; $display("FAIL timeout_hold got %h/%h want ffeeddcc/00112233", l32, r32);
    end
    total++; if (v32_cnt - v0 !== 0 || f32_cnt - f0 !== 0) begin
      bad++; $display("FAIL timeout_pulses got %0d/%0d want 0/0", v32_cnt - v0, f32_cnt - f0);
    end
  endtask

  task automatic test_reset_midframe();
    push_slot(1'b1, 32'h55555555, 32);
    push_slot(1'b0, 32'h66666666, 32);
    push_slot(1'b1, 32'hC0FFEE11, 32);
    push_slot(1'b0, 32'h77777777, 32);
    fork
      play();
      begin
        wait_clk(800);
        total++; if (k32 !== 1'b1 || l32 !== 32'hC0FFEE11) begin
          bad++; $display("FAIL midframe_pre got %b/%h want 1/c0ffee11", k32, l32);
        end
        i_reset = 1'b1;
        wait_clk(1);
        i_reset = 1'b0;
        total++; if ({l32, r32, v32, k32, f32} !== 67'h0) begin
          bad++; $display("FAIL midframe_reset32 got %h want 0", {l32, r32, v32, k32, f32});
        end
        total++; if ({l24, r24, v24, k24, f24} !== 51'h0) begin
          bad++; $display("FAIL midframe_reset24 got %h want 0", {l24, r24, v24, k24, f24});
        end
      end
    join
  endtask

  initial begin
    wait_clk(3);
    test_reset();
    i_reset = 1'b0;
    wait_clk(2);
    test_stream();
    test_loop();
    test_frame_error();
    test_dw24();
    test_timeout();
    test_reset_midframe();
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL valid_and_ferr_overlap got %0d want 0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
